// File: rtl/obi_amo_resolver_pkg.sv
// Shared types for the OBI atomic resolver: atop encodings, FSM states and helpers.
package obi_amo_resolver_pkg;

    typedef logic [5:0] atop_t;

    // RISC-V AMO funct5 in bits [4:0] with bit 5 marking an atomic; 0 means plain access.
    typedef enum logic [5:0] {
        AMONONE = 6'h00,
        AMOADD  = 6'h20,
        AMOSWAP = 6'h21,
        AMOLR   = 6'h22,
        AMOSC   = 6'h23,
        AMOXOR  = 6'h24,
        AMOOR   = 6'h28,
        AMOAND  = 6'h2C,
        AMOMIN  = 6'h30,
        AMOMAX  = 6'h34,
        AMOMINU = 6'h38,
        AMOMAXU = 6'h3C
    } obi_atop_e;

    typedef enum logic [2:0] {
        IDLE,
        FWD_REQ,
        FWD_RSP,
        RD_REQ,
        RD_RSP,
        WR_REQ,
        WR_RSP,
        RESP
    } amo_state_e;

    localparam logic [3:0] AmoFullBe = 4'hF;

    function automatic logic is_amo(input atop_t atop);
        case (atop)
            AMOADD, AMOSWAP, AMOLR, AMOSC, AMOXOR, AMOOR, AMOAND,
            AMOMIN, AMOMAX, AMOMINU, AMOMAXU: is_amo = 1'b1;
            default:                          is_amo = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/obi_amo_alu.sv
// Combinational AMO datapath: a is the old memory word, b the request operand.
module obi_amo_alu
    import obi_amo_resolver_pkg::*;
(
    input  atop_t       atop,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result
);

    always_comb begin
        result = b;
        case (atop)
            AMOADD:  result = a + b;
            AMOXOR:  result = a ^ b;
            AMOAND:  result = a & b;
            AMOOR:   result = a | b;
            AMOMIN:  result = ($signed(a) < $signed(b)) ? a : b;
            AMOMAX:  result = ($signed(a) > $signed(b)) ? a : b;
            AMOMINU: result = (a < b) ? a : b;
            AMOMAXU: result = (a > b) ? a : b;
            default: result = b;
        endcase
    end

endmodule

// File: rtl/obi_amo_resolver.sv
// OBI subordinate adapter resolving atomics into read/compute/write on a plain memory port.
// Optional macro OBI_AMO_ALIGN_CHECK_EN: misaligned AMO/LR/SC get an error instead of word alignment.
module obi_amo_resolver
    import obi_amo_resolver_pkg::*;
#(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned IdWidth   = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 sbr_req_i,
    output logic                 sbr_gnt_o,
    input  logic [AddrWidth-1:0] sbr_addr_i,
    input  logic                 sbr_we_i,
    input  logic [3:0]           sbr_be_i,
    input  logic [31:0]          sbr_wdata_i,
    input  logic [IdWidth-1:0]   sbr_aid_i,
    input  logic [5:0]           sbr_atop_i,
    output logic                 sbr_rvalid_o,
    output logic [31:0]          sbr_rdata_o,
    output logic [IdWidth-1:0]   sbr_rid_o,
    output logic                 sbr_err_o,
    output logic                 mgr_req_o,
    input  logic                 mgr_gnt_i,
    output logic [AddrWidth-1:0] mgr_addr_o,
    output logic                 mgr_we_o,
    output logic [3:0]           mgr_be_o,
    output logic [31:0]          mgr_wdata_o,
    input  logic                 mgr_rvalid_i,
    input  logic [31:0]          mgr_rdata_i,
    input  logic                 mgr_err_i
);

    amo_state_e           state;
    atop_t                atop_q;
    logic [31:0]          wdata_q;
    logic [31:0]          old_q;
    logic                 resv_valid;
    logic [AddrWidth-1:2] resv_addr;
    logic                 resv_hit;
    logic                 resv_kill;
    logic [31:0]          alu_result;

    assign sbr_gnt_o = (state == IDLE) && sbr_req_i && !rst_i;
    assign resv_hit  = resv_valid && (resv_addr == sbr_addr_i[AddrWidth-1:2]);
    // Writes and AMOs other than LR to the reserved word break the reservation.
    assign resv_kill = resv_hit && (((sbr_atop_i == AMONONE) && sbr_we_i) ||
                                    (is_amo(sbr_atop_i) && (sbr_atop_i != AMOLR)));

    obi_amo_alu u_alu (
        .atop   (atop_q),
        .a      (mgr_rdata_i),
        .b      (wdata_q),
        .result (alu_result)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            atop_q       <= '0;
            wdata_q      <= '0;
            old_q        <= '0;
            resv_valid   <= 1'b0;
            resv_addr    <= '0;
            sbr_rvalid_o <= 1'b0;
            sbr_rdata_o  <= '0;
            sbr_rid_o    <= '0;
            sbr_err_o    <= 1'b0;
            mgr_req_o    <= 1'b0;
            mgr_addr_o   <= '0;
            mgr_we_o     <= 1'b0;
            mgr_be_o     <= '0;
            mgr_wdata_o  <= '0;
        end else begin
            case (state)
                IDLE: if (sbr_req_i) begin
                    atop_q    <= sbr_atop_i;
                    wdata_q   <= sbr_wdata_i;
                    sbr_rid_o <= sbr_aid_i;
                    if (resv_kill || (sbr_atop_i == AMOSC)) resv_valid <= 1'b0;
                    if (sbr_atop_i == AMONONE) begin
                        state       <= FWD_REQ;
                        mgr_req_o   <= 1'b1;
                        mgr_addr_o  <= sbr_addr_i;
                        mgr_we_o    <= sbr_we_i;
                        mgr_be_o    <= sbr_be_i;
                        mgr_wdata_o <= sbr_wdata_i;
                    end else if (!is_amo(sbr_atop_i)) begin
                        state        <= RESP;
                        sbr_rvalid_o <= 1'b1;
                        sbr_rdata_o  <= '0;
                        sbr_err_o    <= 1'b1;
                    end
`ifdef OBI_AMO_ALIGN_CHECK_EN
                    else if (sbr_addr_i[1:0] != 2'b00) begin
                        state        <= RESP;
                        sbr_rvalid_o <= 1'b1;
                        sbr_rdata_o  <= '0;
                        sbr_err_o    <= 1'b1;
                    end
`endif
                    else if ((sbr_atop_i == AMOSC) && !resv_hit) begin
                        state        <= RESP;
                        sbr_rvalid_o <= 1'b1;
                        sbr_rdata_o  <= 32'd1;
                        sbr_err_o    <= 1'b0;
                    end else begin
                        state      <= RD_REQ;
                        mgr_req_o  <= 1'b1;
                        mgr_addr_o <= {sbr_addr_i[AddrWidth-1:2], 2'b00};
                        mgr_we_o   <= 1'b0;
                        mgr_be_o   <= AmoFullBe;
                    end
                end
                FWD_REQ: if (mgr_gnt_i) begin
                    mgr_req_o <= 1'b0;
                    state     <= FWD_RSP;
                end
                FWD_RSP: if (mgr_rvalid_i) begin
                    state        <= RESP;
                    sbr_rvalid_o <= 1'b1;
                    sbr_rdata_o  <= mgr_rdata_i;
                    sbr_err_o    <= mgr_err_i;
                end
                RD_REQ: if (mgr_gnt_i) begin
                    mgr_req_o <= 1'b0;
                    state     <= RD_RSP;
                end
                RD_RSP: if (mgr_rvalid_i) begin
                    if (mgr_err_i) begin
                        state        <= RESP;
                        sbr_rvalid_o <= 1'b1;
                        sbr_rdata_o  <= '0;
                        sbr_err_o    <= 1'b1;
                    end else if (atop_q == AMOLR) begin
                        resv_valid   <= 1'b1;
                        resv_addr    <= mgr_addr_o[AddrWidth-1:2];
                        state        <= RESP;
                        sbr_rvalid_o <= 1'b1;
                        sbr_rdata_o  <= mgr_rdata_i;
                        sbr_err_o    <= 1'b0;
                    end else begin
                        old_q       <= mgr_rdata_i;
                        state       <= WR_REQ;
                        mgr_req_o   <= 1'b1;
                        mgr_we_o    <= 1'b1;
                        mgr_be_o    <= AmoFullBe;
                        mgr_wdata_o <= (atop_q == AMOSC) ? wdata_q : alu_result;
                    end
                end
                WR_REQ: if (mgr_gnt_i) begin
                    mgr_req_o <= 1'b0;
                    state     <= WR_RSP;
                end
                WR_RSP: if (mgr_rvalid_i) begin
                    state        <= RESP;
                    sbr_rvalid_o <= 1'b1;
                    sbr_rdata_o  <= (atop_q == AMOSC) ? 32'd0 : old_q;
                    sbr_err_o    <= mgr_err_i;
                end
                RESP: begin
                    sbr_rvalid_o <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/obi_amo_resolver.md
Name: obi_amo_resolver

Overview:
- Subordinate-side OBI adapter. Executes the atomic operations encoded in obi_atop_e against a downstream plain memory that has no atop support.
- Non-atomic requests pass through. AMOs become a read, then a compute, then a write. LR/SC use a single reservation register.
- Sits between the interconnect and an SRAM/peripheral port. Handles one transaction at a time; the downstream port never carries atop.

Parameters:
- AddrWidth, 32, address width (≥3).
- IdWidth, 1, upstream aid/rid width (≥1).
- DataWidth is fixed at 32; AMOs operate on full 32-bit words.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- sbr_req_i  in  1  upstream request
- sbr_gnt_o  out  1  upstream grant
- sbr_addr_i  in  AddrWidth  byte address
- sbr_we_i  in  1  write enable; ignored when atop≠AMONONE
- sbr_be_i  in  4  byte enables; ignored for AMOs
- sbr_wdata_i  in  32  write data / AMO operand
- sbr_aid_i  in  IdWidth  transaction id
- sbr_atop_i  in  6  obi_atop_e
- sbr_rvalid_o  out  1  upstream response valid
- sbr_rdata_o  out  32  response data
- sbr_rid_o  out  IdWidth  echoed id
- sbr_err_o  out  1  response error
- mgr_req_o  out  1  downstream request
- mgr_gnt_i  in  1  downstream grant
- mgr_addr_o  out  AddrWidth  downstream address
- mgr_we_o  out  1  downstream write enable
- mgr_be_o  out  4  downstream byte enables
- mgr_wdata_o  out  32  downstream write data
- mgr_rvalid_i  in  1  downstream response valid
- mgr_rdata_i  in  32  downstream read data
- mgr_err_i  in  1  downstream error

Behaviour:
- States: IDLE, FWD_REQ, FWD_RSP, RD_REQ, RD_RSP, WR_REQ, WR_RSP, RESP.
- Reset: state=IDLE, reservation invalid. All outputs are 0: sbr_gnt_o, sbr_rvalid_o, mgr_req_o and all data/addr outputs.
- IDLE: sbr_gnt_o = sbr_req_i (combinational). On req&gnt, register addr/we/be/wdata/aid/atop, then:
  - atop=AMONONE → FWD_REQ.
  - AMOSC with no matching reservation → RESP with rdata=1, no downstream access; the reservation is cleared.
  - Unsupported atop code → RESP with err=1, rdata=0.
  - Any other AMO → RD_REQ.
- Request states: mgr_req_o is held with stable registered fields until mgr_gnt_i, then the state moves to the matching *_RSP state. In RD_REQ, mgr_we_o=0 and mgr_be_o=4'hF.
- Response states: wait for mgr_rvalid_i. mgr_rvalid_i in the same cycle as mgr_gnt_i does not occur (OBI rule). Capture rdata/err.
- FWD_RSP → RESP, forwarding the captured rdata/err.
- RD_RSP, by atop:
  - err → RESP with err=1; no write; reservation unchanged.
  - AMOLR → set reservation {valid, addr[AddrWidth-1:2]}, then RESP with rdata=old.
  - Other AMOs → WR_REQ with wdata = alu(old, operand). AMOSC writes the operand itself.
- WR_REQ: we=1, be=4'hF.
- WR_RSP → RESP:
  - rdata = old value for AMOs, 0 for a successful SC.
  - err = downstream err.
- RESP: sbr_rvalid_o=1 for exactly one cycle with registered rdata/rid/err, then IDLE. sbr_gnt_o=0 outside IDLE.
- Latency (zero-wait downstream, gnt same cycle as req):
  - Pass-through: gnt at T; rvalid at T+3 (FWD_REQ T+1, FWD_RSP T+2, RESP T+3).
  - AMO: rvalid at T+5.
- ALU:
  - SWAP→b; ADD→a+b mod 2^32; XOR/AND/OR bitwise.
  - MIN/MAX signed 32-bit; MINU/MAXU unsigned.
- Reservation:
  - Cleared by any SC (success or fail).
  - Cleared by any granted write or AMO (including LR's own re-read? no: LR sets it) whose word address matches.
  - A new LR overwrites the reservation.
- Reset mid-operation returns the block to IDLE immediately and drops any pending downstream response. The downstream memory must share rst_i.

Optional Feature:
- OBI_AMO_ALIGN_CHECK_EN:
  - Defined: an AMO/LR/SC with addr[1:0]≠0 goes IDLE→RESP with err=1 and no downstream access.
  - Undefined: addr[1:0] is forced to 0 on downstream AMO accesses and no error is raised.

Decomposition:
- obi_pkg gains: amo_state_e (FSM enum), constant AmoFullBe=4'hF, and function is_amo(atop_t).
- Sub-module obi_amo_alu: combinational (atop, a, b) → result.

Test Plan:
- Plain write 0xDEADBEEF to 0x100, be=4'h3, zero-wait mem → downstream we=1, be=3. rvalid 3 cycles after gnt, err=0; a readback returns 0x0000BEEF.
- mem[0x40]=5, AMOADD operand 7 → response rdata=5; mem[0x40]=12; exactly one downstream read and one write observed.
- mem[0x44]=0xFFFFFFFF, AMOMIN operand 1 → mem stays 0xFFFFFFFF. AMOMINU operand 1 → mem=1; rdata=0xFFFFFFFF.
- LR 0x80, then SC 0x80 operand 9 → rdata=0, mem=9. A second SC to 0x80 → rdata=1 and no downstream write.
- LR 0x80, plain write 0x80, SC 0x80 → SC fails: rdata=1.
- Downstream err on AMO read → rvalid with err=1, no write issued.
- Reset asserted in WR_REQ → next cycle mgr_req_o=0, state IDLE, reservation invalid.
